// File: rtl/comma_aligner_10b.sv
// Receive word aligner: finds K28.5 in a 20-bit window, re-frames the stream at
// the comma offset, and tracks LOS/ACQ/SYNC with error-driven loss of sync.
module comma_aligner_10b #(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] data_in,
  input  logic       valid_in,
  input  logic       code_err_in,
  output logic [9:0] data_out,
  output logic       valid_out,
  output logic       comma_det,
  output logic       synced,
  output logic [3:0] offset
);

  localparam int CCW = $clog2(LOCK_COMMAS + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam int GCW = $clog2(GOOD_RUN + 1);

  typedef enum logic [1:0] {ST_LOS, ST_ACQ, ST_SYNC} state_t;

  state_t         state_q, state_d;
  logic [9:0]     prev_q, prev_d;
  logic [3:0]     offset_q, offset_d;
  logic [CCW-1:0] ccnt_q, ccnt_d;
  logic [ECW-1:0] ecnt_q, ecnt_d;
  logic [GCW-1:0] gcnt_q, gcnt_d;
  logic [9:0]     dout_q, dout_d;
  logic           vout_q, vout_d;
  logic           cdet_q, cdet_d;

  logic [19:0] win;
  logic [9:0]  cand [10];
  logic [9:0]  match;
  logic        any_match;
  logic        cur_match;
  logic        sync_err;
  logic [3:0]  first_k;

  always_comb begin
    win = {prev_q, data_in};
    for (int k = 0; k < 10; k++) begin
      cand[k]  = win[19-k -: 10];
      match[k] = (cand[k][9:3] == 7'b0011111) || (cand[k][9:3] == 7'b1100000);
    end
    any_match = |match;
    // Scan downwards so the lowest matching offset is the one left standing.
    first_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) first_k = 4'(k);
    end
    cur_match = match[offset_q];
    sync_err  = (any_match && !cur_match) || code_err_in;
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    offset_d = offset_q;
    ccnt_d   = ccnt_q;
    ecnt_d   = ecnt_q;
    gcnt_d   = gcnt_q;
    dout_d   = dout_q;
    cdet_d   = cdet_q;
    vout_d   = valid_in;
    if (valid_in) begin
      prev_d = data_in;
      case (state_q)
        ST_LOS: begin
          if (any_match) begin
            offset_d = first_k;
            ccnt_d   = CCW'(1);
            ecnt_d   = '0;
            gcnt_d   = '0;
            state_d  = (LOCK_COMMAS == 1) ? ST_SYNC : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (cur_match) begin
            ccnt_d = ccnt_q + CCW'(1);
            if (ccnt_q == CCW'(LOCK_COMMAS - 1)) begin
              state_d = ST_SYNC;
              ecnt_d  = '0;
              gcnt_d  = '0;
            end
          end else if (any_match) begin
            offset_d = first_k;
            ccnt_d   = CCW'(1);
          end
        end
        ST_SYNC: begin
          if (sync_err) begin
            gcnt_d = '0;
            ecnt_d = ecnt_q + ECW'(1);
            if (ecnt_q == ECW'(ERR_LIMIT - 1)) state_d = ST_LOS;
          end else if (gcnt_q == GCW'(GOOD_RUN - 1)) begin
            gcnt_d = '0;
            if (ecnt_q != '0) ecnt_d = ecnt_q - ECW'(1);
          end else begin
            gcnt_d = gcnt_q + GCW'(1);
          end
        end
        default: state_d = ST_LOS;
      endcase
      // The word that moves the offset is itself emitted at the new framing.
      dout_d = cand[offset_d];
      cdet_d = match[offset_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOS;
      prev_q   <= '0;
      offset_q <= '0;
      ccnt_q   <= '0;
      ecnt_q   <= '0;
      gcnt_q   <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      cdet_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      offset_q <= offset_d;
      ccnt_q   <= ccnt_d;
      ecnt_q   <= ecnt_d;
      gcnt_q   <= gcnt_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      cdet_q   <= cdet_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign comma_det = cdet_q;
  assign synced    = (state_q == ST_SYNC);
  assign offset    = offset_q;

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Bench for comma_aligner_10b: serial bit-stream stimulus, per-cycle compare
// against a word-level model, and literal expectations at key points.
module tb_comma_aligner_10b;
  localparam int LOCK = 3;
  localparam int ELIM = 4;
  localparam int GOOD = 16;
  localparam logic [9:0] K28P = 10'b0011111010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       code_err_in = 1'b0;
  logic [9:0] data_out;
  logic       valid_out, comma_det, synced;
  logic [3:0] offset;

  comma_aligner_10b #(.LOCK_COMMAS(LOCK), .ERR_LIMIT(ELIM), .GOOD_RUN(GOOD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .code_err_in(code_err_in), .data_out(data_out), .valid_out(valid_out),
    .comma_det(comma_det), .synced(synced), .offset(offset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Word-level model: state 0=LOS 1=ACQ 2=SYNC
  int m_prev = 0, m_state = 0, m_off = 0, m_cc = 0, m_ec = 0, m_gc = 0;
  int exp_dout = 0, exp_vout = 0, exp_cdet = 0;

  function automatic int cand_at(input int prev, input int din, input int k);
    return (((prev << 10) | din) >> (10 - k)) & 'h3FF;
  endfunction

  function automatic bit is_comma(input int c);
    return ((c >> 3) == 'b0011111) || ((c >> 3) == 'b1100000);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_prev = 0; m_state = 0; m_off = 0; m_cc = 0; m_ec = 0; m_gc = 0;
      exp_dout = 0; exp_vout = 0; exp_cdet = 0;
    end else if (valid_in) begin
      int first;
      bit hit [10];
      bit err;
      first = -1;
      for (int k = 9; k >= 0; k--) begin
        hit[k] = is_comma(cand_at(m_prev, int'(data_in), k));
        if (hit[k]) first = k;
      end
      if (m_state == 0) begin
        if (first >= 0) begin
          m_off = first; m_cc = 1; m_ec = 0; m_gc = 0;
          m_state = (LOCK == 1) ? 2 : 1;
        end
      end else if (m_state == 1) begin
        if (hit[m_off]) begin
          m_cc++;
          if (m_cc == LOCK) begin m_state = 2; m_ec = 0; m_gc = 0; end
        end else if (first >= 0) begin
          m_off = first; m_cc = 1;
        end
      end else begin
        err = (first >= 0 && !hit[m_off]) || code_err_in;
        if (err) begin
          m_ec++; m_gc = 0;
          if (m_ec >= ELIM) m_state = 0;
        end else begin
          m_gc++;
          if (m_gc == GOOD) begin
            m_gc = 0;
            if (m_ec > 0) m_ec--;
          end
        end
      end
      exp_dout = cand_at(m_prev, int'(data_in), m_off);
      exp_cdet = int'(hit[m_off]);
      exp_vout = 1;
      m_prev   = int'(data_in);
    end else begin
      exp_vout = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out",  int'(data_out),  exp_dout);
      check("valid_out", int'(valid_out), exp_vout);
      check("comma_det", int'(comma_det), exp_cdet);
      check("synced",    int'(synced),    (m_state == 2) ? 1 : 0);
      check("offset",    int'(offset),    m_off);
    end
  end

  bit bq[$];

  task automatic step(input logic [9:0] d, input logic v, input logic ce);
    data_in = d; valid_in = v; code_err_in = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(w[i]);
  endtask

  task automatic send(input logic ce);
    logic [9:0] w;
    while (bq.size() >= 10) begin
      for (int i = 9; i >= 0; i--) w[i] = bq.pop_front();
      step(w, 1'b1, ce);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(10'h0, 1'b0, 1'b0);
    step(10'h0, 1'b0, 1'b0);
    rst = 1'b0;
    bq.delete();
  endtask

  task automatic lock_at3(input int ncommas);
    do_reset();
    push(10'h0, 3);
    repeat (ncommas) push(K28P, 10);
    send(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk_en = 1;
    check("rst_synced", int'(synced), 0);
    check("rst_offset", int'(offset), 0);
    check("rst_vout",   int'(valid_out), 0);
    check("rst_dout",   int'(data_out), 0);

    // 1: K28.5- stream shifted by 3 bits
    lock_at3(3);
    check("t1_not_yet_synced", int'(synced), 0);
    push(K28P, 10); send(1'b0);
    check("t1_synced_3rd", int'(synced), 1);
    repeat (4) push(K28P, 10);
    send(1'b0);
    check("t1_offset", int'(offset), 3);
    check("t1_dout", int'(data_out), int'(K28P));
    check("t1_cdet", int'(comma_det), 1);

    // 2: one comma slipped to offset 6 while locked
    push(10'h0, 3); push(K28P, 10); push(10'h0, 7);
    repeat (3) push(K28P, 10);
    send(1'b0);
    check("t2_offset", int'(offset), 3);
    check("t2_synced", int'(synced), 1);
    check("t2_model_ecnt", m_ec, 1);

    // 3: four code errors drop sync
    lock_at3(4);
    for (int i = 0; i < 4; i++) begin
      push(K28P, 10); send(1'b1);
      check("t3_synced", int'(synced), (i < 3) ? 1 : 0);
    end
    check("t3_offset_hold", int'(offset), 3);

    // 4: one error then a 16-word good run
    lock_at3(4);
    push(K28P, 10); send(1'b1);
    repeat (15) begin push(K28P, 10); send(1'b0); end
    check("t4_model_ecnt15", m_ec, 1);
    push(K28P, 10); send(1'b0);
    check("t4_model_ecnt16", m_ec, 0);
    repeat (3) begin push(K28P, 10); send(1'b1); end
    check("t4_synced_3err", int'(synced), 1);
    push(K28P, 10); send(1'b1);
    check("t4_synced_4err", int'(synced), 0);

    // 5: ACQ at offset 2 then comma at offset 7
    do_reset();
    push(10'h0, 2); push(K28P, 10); push(K28P, 10);
    send(1'b0);
    check("t5_acq_off2", int'(offset), 2);
    push(10'h0, 5); push(K28P, 10); push(10'b1010101010, 10);
    send(1'b0);
    check("t5_offset7", int'(offset), 7);
    check("t5_model_ccnt", m_cc, 1);
    check("t5_not_synced", int'(synced), 0);
    check("t5_dout", int'(data_out), int'(K28P));
    check("t5_cdet", int'(comma_det), 1);
    repeat (3) push(K28P, 10);
    send(1'b0);
    check("t5_synced", int'(synced), 1);
    check("t5_offset_final", int'(offset), 7);

    // 6a: valid toggling during lock
    do_reset();
    push(10'h0, 3);
    repeat (4) push(K28P, 10);
    for (int i = 1; i <= 4; i++) begin
      logic [9:0] w;
      for (int b = 9; b >= 0; b--) w[b] = bq.pop_front();
      step(w, 1'b1, 1'b0);
      step(K28P, 1'b0, 1'b1);
      check("t6_idle_vout", int'(valid_out), 0);
      if (i == 3) check("t6_synced_w3", int'(synced), 0);
      if (i == 4) check("t6_synced_w4", int'(synced), 1);
    end

    // 6b: reset asserted mid-ACQ
    do_reset();
    push(10'h0, 3); push(K28P, 10); push(K28P, 10);
    send(1'b0);
    check("t6_acq_off3", int'(offset), 3);
    rst = 1'b1;
    step(K28P, 1'b1, 1'b0);
    check("t6_rst_synced", int'(synced), 0);
    check("t6_rst_offset", int'(offset), 0);
    check("t6_rst_vout",   int'(valid_out), 0);
    check("t6_rst_dout",   int'(data_out), 0);
    rst = 1'b0;
    step(10'h0, 1'b0, 1'b0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
